// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Multi-cycle execute sequencer for the LC-3 ADD, AND and NOT ops.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_ctrl #(
   parameter int RF_LAT = 1,
   parameter int WIDTH  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [15:0]      ir,
   output logic [2:0]       rf_raddr1,
   output logic [2:0]       rf_raddr2,
   input  logic [WIDTH-1:0] rf_rdata1,
   input  logic [WIDTH-1:0] rf_rdata2,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rf_we,
   output logic [2:0]       rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic [2:0]       nzp,
   output logic             done,
   output logic             illegal
);

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_READ = 3'd1;
   localparam logic [2:0] c_ST_EXEC = 3'd2;
   localparam logic [2:0] c_ST_WB   = 3'd3;
   localparam logic [2:0] c_ST_ERR  = 3'd4;

   localparam logic [3:0] c_OP_ADD  = 4'b0001;
   localparam logic [3:0] c_OP_AND  = 4'b0101;
   localparam logic [3:0] c_OP_NOT  = 4'b1001;

   localparam logic [2:0] c_RD_LAST = 3'(RF_LAT - 1);
   localparam logic [2:0] c_NZP_RST = 3'b010;

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [2:0]       r_rd_cnt;
   logic [3:0]       r_op;
   logic             r_imm_sel;
   logic [4:0]       r_imm5;

   logic             w_handshake;
   logic             w_legal;
   logic             w_rd_last;
   logic [WIDTH-1:0] w_imm_sext;
   logic [WIDTH-1:0] w_opnd_b;
   logic [2:0]       w_nzp_res;

   assign issue_ready = (r_state == c_ST_IDLE);
   assign w_handshake = issue_valid && issue_ready;
   assign w_rd_last   = (r_state == c_ST_READ) && (r_rd_cnt == c_RD_LAST);

   // NOT is only a valid encoding with its low six bits all ones
   assign w_legal = (ir[15:12] == c_OP_ADD) ||
                    (ir[15:12] == c_OP_AND) ||
                    ((ir[15:12] == c_OP_NOT) && (ir[5:0] == 6'b111111));

   assign w_imm_sext = {{(WIDTH-5){r_imm5[4]}}, r_imm5};

   always_comb begin
      w_opnd_b = rf_rdata2;
      if (r_op == c_OP_NOT) begin
         w_opnd_b = '0;
      end else if (r_imm_sel) begin
         w_opnd_b = w_imm_sext;
      end
   end

   always_comb begin
      w_nzp_res = 3'b001;
      if (rf_wdata[WIDTH-1]) begin
         w_nzp_res = 3'b100;
      end else if (rf_wdata == '0) begin
         w_nzp_res = 3'b010;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (w_handshake) w_state_nxt = w_legal ? c_ST_READ : c_ST_ERR;
         c_ST_READ: if (w_rd_last)   w_state_nxt = c_ST_EXEC;
         c_ST_EXEC: w_state_nxt = c_ST_WB;
         c_ST_WB:   w_state_nxt = c_ST_IDLE;
         c_ST_ERR:  w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_ST_IDLE;
         r_rd_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == c_ST_READ) begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
         end else begin
            r_rd_cnt <= '0;
         end
      end
   end

   // Source addresses and destination are taken straight from the accepted word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_imm_sel <= 1'b0;
         r_imm5    <= '0;
         rf_raddr1 <= '0;
         rf_raddr2 <= '0;
         rf_waddr  <= '0;
      end else if (w_handshake) begin
         r_op      <= ir[15:12];
         r_imm_sel <= ir[5];
         r_imm5    <= ir[4:0];
         rf_raddr1 <= ir[8:6];
         rf_raddr2 <= ir[2:0];
         rf_waddr  <= ir[11:9];
      end
   end

   // Operands are loaded on the last READ edge so the ALU sees them for all of EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         rf_wdata <= '0;
      end else begin
         if (w_rd_last) begin
            alu_op <= r_op;
            alu_a  <= rf_rdata1;
            alu_b  <= w_opnd_b;
         end
         if (r_state == c_ST_EXEC) begin
            rf_wdata <= alu_out;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we   <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         nzp     <= c_NZP_RST;
      end else begin
         rf_we   <= (r_state == c_ST_EXEC);
         done    <= (r_state == c_ST_EXEC);
         illegal <= w_handshake && !w_legal;
         if (r_state == c_ST_WB) begin
            nzp <= w_nzp_res;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// Bench for alu_exec_ctrl: two instances (RF_LAT=1 and RF_LAT=3) with their own
// register file and ALU models, checked against a queue of expected retirements.
module tb_alu_exec_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  iv, rdy, we, done, ill;
   logic [15:0] irw  [2];
   logic [2:0]  ra1  [2];
   logic [2:0]  ra2  [2];
   logic [15:0] rd1  [2];
   logic [15:0] rd2  [2];
   logic [3:0]  op   [2];
   logic [15:0] aa   [2];
   logic [15:0] bb   [2];
   logic [15:0] alu_o[2];
   logic [2:0]  wa   [2];
   logic [15:0] wd   [2];
   logic [2:0]  nzp_o[2];

   logic [15:0] rf   [2][8];
   logic [15:0] m    [2][8];
   logic [2:0]  mnzp [2];
   logic [1:0]  tb_we;
   logic [2:0]  tb_wa [2];
   logic [15:0] tb_wd [2];
   logic [2:0]  a1d0, a1d1, a2d0, a2d1;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int          s;
      logic        ill;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [2:0]  nz;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   logic [1:0] nz_pend;
   logic [2:0] nz_exp [2];

   alu_exec_ctrl #(.RF_LAT(1), .WIDTH(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .issue_valid(iv[0]), .issue_ready(rdy[0]), .ir(irw[0]),
      .rf_raddr1(ra1[0]), .rf_raddr2(ra2[0]), .rf_rdata1(rd1[0]), .rf_rdata2(rd2[0]),
      .alu_op(op[0]), .alu_a(aa[0]), .alu_b(bb[0]), .alu_out(alu_o[0]),
      .rf_we(we[0]), .rf_waddr(wa[0]), .rf_wdata(wd[0]), .nzp(nzp_o[0]),
      .done(done[0]), .illegal(ill[0])
   );

   alu_exec_ctrl #(.RF_LAT(3), .WIDTH(16)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .issue_valid(iv[1]), .issue_ready(rdy[1]), .ir(irw[1]),
      .rf_raddr1(ra1[1]), .rf_raddr2(ra2[1]), .rf_rdata1(rd1[1]), .rf_rdata2(rd2[1]),
      .alu_op(op[1]), .alu_a(aa[1]), .alu_b(bb[1]), .alu_out(alu_o[1]),
      .rf_we(we[1]), .rf_waddr(wa[1]), .rf_wdata(wd[1]), .nzp(nzp_o[1]),
      .done(done[1]), .illegal(ill[1])
   );

   function automatic logic [15:0] alu_f(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
      case (o)
         4'b0001: return a + b;
         4'b0101: return a & b;
         4'b1001: return ~a;
         default: return 16'h0000;
      endcase
   endfunction

   assign alu_o[0] = alu_f(op[0], aa[0], bb[0]);
   assign alu_o[1] = alu_f(op[1], aa[1], bb[1]);

   // Slow register file: data for an address appears RF_LAT-1 cycles later
   assign rd1[0] = rf[0][ra1[0]];
   assign rd2[0] = rf[0][ra2[0]];
   assign rd1[1] = rf[1][a1d1];
   assign rd2[1] = rf[1][a2d1];

   always_ff @(posedge clk) begin
      cyc  <= cyc + 1;
      a1d0 <= ra1[1];
      a1d1 <= a1d0;
      a2d0 <= ra2[1];
      a2d1 <= a2d0;
      for (int s = 0; s < 2; s++) begin
         if (tb_we[s]) rf[s][tb_wa[s]] <= tb_wd[s];
         else if (we[s]) rf[s][wa[s]] <= wd[s];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Retirement monitor: every done/illegal/rf_we event pops one expected entry
   initial begin
      exp_t e;
      nz_pend = 2'b00;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            if (nz_pend[s]) begin
               check_eq("nzp_after_retire", 32'(nzp_o[s]), 32'(nz_exp[s]));
               nz_pend[s] = 1'b0;
            end
            if (done[s] || ill[s] || we[s]) begin
               if (sbq.size() == 0 || sbq[0].s != s) begin
                  check_eq("unexpected_event", {29'd0, done[s], ill[s], we[s]}, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  check_eq("event_cycle", cyc, e.cyc);
                  check_eq("illegal", 32'(ill[s]), 32'(e.ill));
                  check_eq("done", 32'(done[s]), 32'(!e.ill));
                  check_eq("rf_we", 32'(we[s]), 32'(!e.ill));
                  if (!e.ill) begin
                     check_eq("rf_waddr", 32'(wa[s]), 32'(e.wa));
                     check_eq("rf_wdata", 32'(wd[s]), 32'(e.wd));
                  end
                  nz_pend[s] = 1'b1;
                  nz_exp[s]  = e.nz;
               end
            end
         end
      end
   end

   task automatic set_reg(input int s, input logic [2:0] a, input logic [15:0] d);
      @(negedge clk); #2;
      tb_we[s] = 1'b1; tb_wa[s] = a; tb_wd[s] = d;
      @(negedge clk); #2;
      tb_we[s] = 1'b0;
      m[s][a] = d;
   endtask

   task automatic exec(input int s, input logic [15:0] instr, input int abort_k);
      int          lat, kend;
      logic [3:0]  o;
      logic        legal;
      logic [15:0] a, b, res;
      logic [2:0]  nz;
      exp_t        e;
      lat   = (s == 0) ? 1 : 3;
      o     = instr[15:12];
      legal = (o == 4'b0001) || (o == 4'b0101) || (o == 4'b1001 && instr[5:0] == 6'b111111);
      a     = m[s][instr[8:6]];
      if (o == 4'b1001)   b = 16'h0000;
      else if (instr[5])  b = {{11{instr[4]}}, instr[4:0]};
      else                b = m[s][instr[2:0]];
      case (o)
         4'b0001: res = a + b;
         4'b0101: res = a & b;
         default: res = ~a;
      endcase
      nz = res[15] ? 3'b100 : ((res == 16'h0000) ? 3'b010 : 3'b001);

      @(negedge clk); #2;
      check_eq("ready_before_issue", 32'(rdy[s]), 32'd1);
      iv[s]  = 1'b1;
      irw[s] = instr;
      e.s   = s;
      e.ill = !legal;
      e.wa  = instr[11:9];
      e.wd  = res;
      e.nz  = legal ? nz : mnzp[s];
      e.cyc = cyc + (legal ? lat + 2 : 1);
      sbq.push_back(e);
      kend = legal ? lat + 3 : 2;

      for (int k = 1; k <= kend; k++) begin
         @(negedge clk); #2;
         if (k == 1) begin
            iv[s]  = 1'b0;
            irw[s] = 16'hFFFF;
         end
         if (k == abort_k) begin
            rst_n = 1'b0;
            #1;
            check_eq("abort_ready", 32'(rdy[s]), 32'd1);
            check_eq("abort_we", 32'(we[s]), 32'd0);
            check_eq("abort_done", 32'(done[s]), 32'd0);
            check_eq("abort_nzp", 32'(nzp_o[s]), 32'b010);
            sbq.delete();
            mnzp[0] = 3'b010;
            mnzp[1] = 3'b010;
            @(negedge clk); #2;
            rst_n = 1'b1;
            return;
         end
         if (legal) begin
            if (k <= lat) begin
               check_eq("ready_in_read", 32'(rdy[s]), 32'd0);
               check_eq("raddr1_hold", 32'(ra1[s]), 32'(instr[8:6]));
               check_eq("raddr2_hold", 32'(ra2[s]), 32'(instr[2:0]));
            end else if (k == lat + 1) begin
               check_eq("ready_in_exec", 32'(rdy[s]), 32'd0);
               check_eq("alu_op", 32'(op[s]), 32'(o));
               check_eq("alu_a", 32'(aa[s]), 32'(a));
               check_eq("alu_b", 32'(bb[s]), 32'(b));
            end else if (k == lat + 2) begin
               check_eq("ready_in_wb", 32'(rdy[s]), 32'd0);
            end else begin
               check_eq("ready_after_wb", 32'(rdy[s]), 32'd1);
            end
         end else begin
            check_eq(k == 1 ? "ready_in_err" : "ready_after_err", 32'(rdy[s]), (k == 1) ? 32'd0 : 32'd1);
         end
      end
      if (legal) begin
         m[s][instr[11:9]] = res;
         mnzp[s] = nz;
      end
      check_eq("scoreboard_drained", sbq.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ri;
      int          pick;
      rst_n  = 1'b0;
      iv     = 2'b00;
      irw[0] = 16'h0000;
      irw[1] = 16'h0000;
      tb_we  = 2'b00;
      tb_wa[0] = 3'd0; tb_wa[1] = 3'd0;
      tb_wd[0] = 16'h0; tb_wd[1] = 16'h0;
      mnzp[0] = 3'b010;
      mnzp[1] = 3'b010;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk); #2;

      check_eq("rst_ready", 32'(rdy[0]), 32'd1);
      check_eq("rst_we", 32'(we[0]), 32'd0);
      check_eq("rst_done", 32'(done[0]), 32'd0);
      check_eq("rst_illegal", 32'(ill[0]), 32'd0);
      check_eq("rst_alu_op", 32'(op[0]), 32'd0);
      check_eq("rst_alu_a", 32'(aa[0]), 32'd0);
      check_eq("rst_alu_b", 32'(bb[0]), 32'd0);
      check_eq("rst_wdata", 32'(wd[0]), 32'd0);
      check_eq("rst_waddr", 32'(wa[0]), 32'd0);
      check_eq("rst_raddr", {26'd0, ra1[0], ra2[0]}, 32'd0);
      check_eq("rst_nzp", 32'(nzp_o[0]), 32'b010);
      check_eq("rst_nzp_lat3", 32'(nzp_o[1]), 32'b010);

      for (int r = 0; r < 8; r++) begin
         set_reg(0, 3'(r), 16'h0000);
         set_reg(1, 3'(r), 16'h0000);
      end

      set_reg(0, 3'd1, 16'd5);
      set_reg(0, 3'd2, 16'd7);
      exec(0, 16'h1642, 0);
      set_reg(0, 3'd1, 16'd3);
      exec(0, 16'h1270, 0);
      set_reg(0, 3'd1, 16'h1234);
      exec(0, 16'h5460, 0);
      set_reg(0, 3'd4, 16'h00FF);
      exec(0, 16'h9B3F, 0);
      exec(0, 16'h0000, 0);
      exec(0, 16'h983E, 0);
      set_reg(0, 3'd1, 16'h7FFF);
      exec(0, 16'h1261, 0);

      set_reg(1, 3'd1, 16'h7FFF);
      exec(1, 16'h1261, 0);
      set_reg(1, 3'd2, 16'h0010);
      set_reg(1, 3'd3, 16'h0020);
      exec(1, 16'h1483, 0);
      exec(1, 16'hD000, 0);

      set_reg(0, 3'd1, 16'd5);
      set_reg(0, 3'd2, 16'd7);
      exec(0, 16'h1642, 2);
      exec(0, 16'h1642, 0);

      for (int i = 0; i < 8; i++) begin
         set_reg(0, 3'($urandom_range(0, 7)), 16'($urandom));
         pick = $urandom_range(0, 2);
         ri   = 16'($urandom);
         if (pick == 0)      ri[15:12] = 4'b0001;
         else if (pick == 1) ri[15:12] = 4'b0101;
         else begin
            ri[15:12] = 4'b1001;
            ri[5:0]   = 6'b111111;
         end
         exec(0, ri, 0);
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute-stage sequencer for the LC-3 operate instructions ADD, AND and NOT.
- Accepts one 16-bit instruction word per handshake and decodes its fields.
- Reads source registers from the register file, drives the combinational ALU, writes the result back, and maintains the NZP condition-code register.
- Sits between the decode stage and the register file/ALU pair.

Parameters:
- RF_LAT, 1: register-file read latency in cycles (legal 1..4); raddr is held stable for this many cycles.
- WIDTH, 16: datapath width; the LC-3 field layout is fixed, so only 16 is tested.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- issue_valid  input  1  decode presents an instruction.
- issue_ready  output  1  controller can accept an instruction.
- ir  input  16  instruction word, sampled on the handshake.
- rf_raddr1  output  3  SR1 read address, IR[8:6].
- rf_raddr2  output  3  SR2 read address, IR[2:0].
- rf_rdata1  input  16  SR1 read data.
- rf_rdata2  input  16  SR2 read data.
- alu_op  output  4  ALU opcode: 0001 ADD, 0101 AND, 1001 NOT.
- alu_a  output  16  ALU operand A.
- alu_b  output  16  ALU operand B.
- alu_out  input  16  ALU result, combinational from alu_a/alu_b/alu_op.
- rf_we  output  1  register-file write enable, 1-cycle pulse.
- rf_waddr  output  3  destination register, IR[11:9].
- rf_wdata  output  16  write-back data.
- nzp  output  3  condition codes {N,Z,P}, one-hot.
- done  output  1  1-cycle pulse: instruction retired.
- illegal  output  1  1-cycle pulse: instruction rejected.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state goes to IDLE; issue_ready=1.
  - rf_we, done, illegal = 0; alu_op = 0000.
  - alu_a, alu_b, rf_wdata = 0; rf_waddr, rf_raddr1/2 = 0.
  - nzp = 3'b010.
- FSM states are IDLE, READ, EXEC, WB, ERR.
- IDLE:
  - issue_ready=1 only in IDLE.
  - Handshake (issue_valid && issue_ready) latches ir internally.
  - Next state is READ if IR[15:12] is 0001, 0101 or 1001; otherwise ERR.
  - ir is ignored while issue_ready=0.
- READ:
  - raddr1/raddr2 driven from the latched IR and held for RF_LAT cycles (counter).
  - On the last READ cycle, rdata1/rdata2 are captured into operand registers; next state EXEC.
- Operand B selection:
  - ADD/AND with IR[5]=1: B = sign-extended IR[4:0].
  - ADD/AND with IR[5]=0: B = captured rdata2.
  - NOT: B = 0.
  - A = captured rdata1 in all cases.
- EXEC (1 cycle):
  - alu_op, alu_a and alu_b are registered outputs, stable for the whole cycle.
  - alu_out is captured at the end of EXEC; next state WB.
- WB (1 cycle):
  - rf_we=1, rf_waddr=IR[11:9], rf_wdata=captured result, done=1.
  - nzp updates on the closing edge: N=result[15], Z=(result==0), P=otherwise. Exactly one bit is set.
  - Next state IDLE.
- ERR (1 cycle):
  - illegal=1; no rf_we; nzp unchanged; next state IDLE.
- NOT encoding check: IR[5:0] must be 111111, otherwise the instruction goes to ERR.
- Latency:
  - Accept in cycle 0; READ occupies cycles 1..RF_LAT; EXEC is cycle RF_LAT+1; WB/done is cycle RF_LAT+2.
  - issue_ready is high again in cycle RF_LAT+3.
  - Minimum issue spacing is RF_LAT+3 cycles.
- Arithmetic is mod 2^16; overflow is not flagged. Example: 0x7FFF+1 = 0x8000, N set.
- DR equal to SR1/SR2 is legal: sources are captured before write-back, so there is no hazard.
- Reset in any state:
  - aborts the instruction immediately; no partial write-back.
  - nzp reverts to 010.
- issue_valid dropping before the handshake has no effect.

Test Plan:
- R1=5, R2=7; issue 0x1642 (ADD R3,R1,R2), RF_LAT=1 -> issue_ready low cycles 1-3; rf_we/done in cycle 3 with waddr=3, wdata=0x000C; nzp=001 in cycle 4.
- R1=3; issue 0x1270 (ADD R1,R1,#-16) -> alu_b=0xFFF0, wdata=0xFFF3 to R1, nzp=100.
- R1=0x1234; issue 0x5460 (AND R2,R1,#0) -> wdata=0x0000, nzp=010. Then R4=0x00FF, issue 0x9B3F (NOT R5,R4) -> wdata=0xFF00, nzp=100.
- Issue 0x0000 and 0x983E (NOT with bad low bits) -> illegal pulse in cycle 1, no rf_we, nzp unchanged, issue_ready high in cycle 2.
- R1=0x7FFF; issue 0x1261 (ADD R1,R1,#1) -> wdata=0x8000, nzp=100. Repeat with RF_LAT=3 -> done in cycle 5, raddr stable for cycles 1-3.
- Assert rst_n=0 during EXEC -> no rf_we or done, nzp=010, issue_ready=1 immediately; the next legal issue completes normally.
